// File: rtl/ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// ps2_scancode_rx
//
// Input stage for the Space Invaders core. It receives raw PS/2 keyboard pins,
// deframes the 11-bit frames (start, 8 data bits LSB first, odd parity, stop)
// and turns scan-code-set-2 byte sequences into single key events for the
// game-logic key-state register.
//
// Ports:
//   CLK_25MHZ       in   system clock, the only clock
//   RESET           in   asynchronous, active-high reset
//   PS2_CLK         in   raw keyboard clock (asynchronous to CLK_25MHZ)
//   PS2_DATA        in   raw keyboard data  (asynchronous to CLK_25MHZ)
//   EVENT_VALID     out  one-cycle strobe, a key event is present
//   EVENT_CODE      out  scan code with E0/F0 prefixes stripped (held)
//   EVENT_EXTENDED  out  code was preceded by E0 (held)
//   EVENT_PRESSED   out  1 = make, 0 = break (held)
//   FRAME_ERROR     out  one-cycle strobe on parity, stop or timeout error
//
// Parameters:
//   SYNC_STAGES     metastability flops per pin (>= 2)
//   FILTER_LEN      consecutive equal clock samples needed to move the
//                   filtered PS/2 clock
//   TIMEOUT_CYCLES  idle clocks allowed between falling edges in a frame
//                   (>= 2)
// -----------------------------------------------------------------------------
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       EVENT_VALID,
    output logic [7:0] EVENT_CODE,
    output logic       EVENT_EXTENDED,
    output logic       EVENT_PRESSED,
    output logic       FRAME_ERROR
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(FILTER_LEN - 1);
    // The timeout fires on the edge where the counter would step onto
    // TIMEOUT_CYCLES-1, so the error lands exactly TIMEOUT_CYCLES cycles
    // after the last falling-edge cycle.
    localparam logic [TO_W-1:0]   TO_TRIGGER = TO_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // -------------------------------------------------------------------------
    // Pin synchronizers. Both idle high, so reset loads ones to avoid a
    // phantom falling edge after reset release.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], PS2_CLK};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], PS2_DATA};
        end
    end

    assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Clock deglitch filter. The counter measures how long the synchronized
    // clock has disagreed with the filtered one; any agreement restarts it,
    // so pulses shorter than FILTER_LEN cycles never reach the filtered clock.
    // -------------------------------------------------------------------------
    logic              filt_clk_reg;
    logic              filt_clk_prev_reg;
    logic [FILT_W-1:0] filt_cnt_reg;
    logic              fe;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            filt_clk_reg      <= 1'b1;
            filt_clk_prev_reg <= 1'b1;
            filt_cnt_reg      <= '0;
        end else begin
            filt_clk_prev_reg <= filt_clk_reg;
            if (clk_s != filt_clk_reg) begin
                if (filt_cnt_reg == FILT_LAST) begin
                    filt_clk_reg <= clk_s;
                    filt_cnt_reg <= '0;
                end else begin
                    filt_cnt_reg <= filt_cnt_reg + 1'b1;
                end
            end else begin
                filt_cnt_reg <= '0;
            end
        end
    end

    // Falling-edge cycle: the first cycle in which the filtered clock reads 0.
    assign fe = filt_clk_prev_reg & ~filt_clk_reg;

    // -------------------------------------------------------------------------
    // Frame FSM, timeout and scan-code decoder state.
    // -------------------------------------------------------------------------
    frame_state_t    state_reg,        state_next;
    logic [2:0]      bit_cnt_reg,      bit_cnt_next;
    logic [7:0]      shift_reg,        shift_next;
    logic            parity_reg,       parity_next;
    logic [TO_W-1:0] to_cnt_reg,       to_cnt_next;
    logic            ext_flag_reg,     ext_flag_next;
    logic            brk_flag_reg,     brk_flag_next;
    logic [2:0]      swallow_cnt_reg,  swallow_cnt_next;
    logic            event_valid_reg,  event_valid_next;
    logic [7:0]      event_code_reg,   event_code_next;
    logic            event_ext_reg,    event_ext_next;
    logic            event_press_reg,  event_press_next;
    logic            frame_error_reg,  frame_error_next;

    logic            byte_good;
    logic            frame_bad;
    logic            is_response;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            to_cnt_reg      <= '0;
            ext_flag_reg    <= 1'b0;
            brk_flag_reg    <= 1'b0;
            swallow_cnt_reg <= '0;
            event_valid_reg <= 1'b0;
            event_code_reg  <= '0;
            event_ext_reg   <= 1'b0;
            event_press_reg <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            to_cnt_reg      <= to_cnt_next;
            ext_flag_reg    <= ext_flag_next;
            brk_flag_reg    <= brk_flag_next;
            swallow_cnt_reg <= swallow_cnt_next;
            event_valid_reg <= event_valid_next;
            event_code_reg  <= event_code_next;
            event_ext_reg   <= event_ext_next;
            event_press_reg <= event_press_next;
            frame_error_reg <= frame_error_next;
        end
    end

    // Keyboard self-test / ack / echo / resend / failure responses.
    assign is_response = (shift_reg == 8'hAA) || (shift_reg == 8'hFA) ||
                         (shift_reg == 8'hEE) || (shift_reg == 8'hFE) ||
                         (shift_reg == 8'hFC);

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        parity_next      = parity_reg;
        to_cnt_next      = to_cnt_reg;
        ext_flag_next    = ext_flag_reg;
        brk_flag_next    = brk_flag_reg;
        swallow_cnt_next = swallow_cnt_reg;
        event_valid_next = 1'b0;
        event_code_next  = event_code_reg;
        event_ext_next   = event_ext_reg;
        event_press_next = event_press_reg;
        frame_error_next = 1'b0;
        byte_good        = 1'b0;
        frame_bad        = 1'b0;

        // Bit deframing, one step per falling edge.
        case (state_reg)
            ST_IDLE: begin
                // A high data line at a falling edge is a spurious start.
                if (fe && !data_s) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (fe) begin
                    shift_next = {data_s, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fe) begin
                    parity_next = data_s;
                    state_next  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fe) begin
                    state_next = ST_IDLE;
                    if (data_s && ((^shift_reg) ^ parity_reg)) begin
                        byte_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Inter-edge watchdog; a stalled keyboard must not wedge the FSM.
        if (state_reg == ST_IDLE || fe) begin
            to_cnt_next = '0;
        end else if (to_cnt_reg == TO_TRIGGER) begin
            to_cnt_next = '0;
            state_next  = ST_IDLE;
            frame_bad   = 1'b1;
        end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end

        // Scan-code decoder. The outputs are registered, so an event or
        // error appears in the cycle after the stop-bit falling edge.
        if (frame_bad) begin
            frame_error_next = 1'b1;
            ext_flag_next    = 1'b0;
            brk_flag_next    = 1'b0;
            swallow_cnt_next = '0;
        end else if (byte_good) begin
            if (swallow_cnt_reg != 3'd0) begin
                // Inside the Pause sequence: drop the byte, keep flags as is.
                swallow_cnt_next = swallow_cnt_reg - 3'd1;
            end else if (shift_reg == 8'hE0) begin
                ext_flag_next = 1'b1;
            end else if (shift_reg == 8'hF0) begin
                brk_flag_next = 1'b1;
            end else if (shift_reg == 8'hE1) begin
                // Pause key: E1 is followed by 7 more bytes with no release.
                swallow_cnt_next = 3'd7;
            end else if (is_response && !ext_flag_reg && !brk_flag_reg) begin
                // Device response, not a key: nothing to report.
                swallow_cnt_next = swallow_cnt_reg;
            end else begin
                event_valid_next = 1'b1;
                event_code_next  = shift_reg;
                event_ext_next   = ext_flag_reg;
                event_press_next = ~brk_flag_reg;
                ext_flag_next    = 1'b0;
                brk_flag_next    = 1'b0;
            end
        end
    end

    assign EVENT_VALID    = event_valid_reg;
    assign EVENT_CODE     = event_code_reg;
    assign EVENT_EXTENDED = event_ext_reg;
    assign EVENT_PRESSED  = event_press_reg;
    assign FRAME_ERROR    = frame_error_reg;

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Upstream input stage of the Space Invaders core.
- Samples the raw PS/2 keyboard pins and deframes 11-bit PS/2 frames.
- Decodes scan-code-set-2 prefixes (E0 extended, F0 break) into single key events.
- The game-logic key-state register consumes these events.

Parameters:
- SYNC_STAGES, 2, number of metastability flops on each PS/2 pin (minimum 2).
- FILTER_LEN, 8, consecutive equal synchronized PS2_CLK samples required before the filtered clock changes.
- TIMEOUT_CYCLES, 25000, idle clocks allowed between falling edges inside a frame before abort (1 ms at 25 MHz).

Ports:
- CLK_25MHZ  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- PS2_CLK  in  1  raw keyboard clock, asynchronous.
- PS2_DATA  in  1  raw keyboard data, asynchronous.
- EVENT_VALID  out  1  one-cycle strobe; a key event is present.
- EVENT_CODE  out  8  scan code with prefixes stripped.
- EVENT_EXTENDED  out  1  1 if the code was preceded by E0.
- EVENT_PRESSED  out  1  1 = make, 0 = break (preceded by F0).
- FRAME_ERROR  out  1  one-cycle strobe on parity, stop or timeout error.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all outputs to 0;
  - sync flops and filtered clock to 1;
  - frame FSM to IDLE;
  - bit count, shift register, timeout counter and prefix flags to 0.
  Reset asserted mid-frame discards the partial frame. After release, reception resumes at the next start bit.
- Synchronization: each pin passes through SYNC_STAGES flops.
- Clock filter:
  - The filter counter increments while the synchronized clock differs from the filtered clock and clears otherwise.
  - When the counter reaches FILTER_LEN-1, the filtered clock toggles on the next edge.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Falling-edge event (FE): the cycle in which the filtered clock goes 1->0. Data is sampled from the synchronized PS2_DATA on that cycle.
- Frame FSM, advancing only on FE:
  - IDLE: data 0 -> DATA with bit count 0. Data 1 is a spurious start; stay in IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: the frame is good if stop = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity). Good frame -> byte handed to the decoder. Bad frame -> FRAME_ERROR pulse. Return to IDLE in both cases.
- Timeout:
  - The counter clears on every FE and in IDLE; otherwise it increments.
  - At TIMEOUT_CYCLES-1 in any non-IDLE state: go to IDLE, pulse FRAME_ERROR, discard the byte.
- Any FRAME_ERROR also clears the E0/F0/E1 prefix flags.
- Decoder, one byte per good frame; the byte is handled in the cycle after the STOP FE:
  - E0: set ext flag, no event.
  - F0: set brk flag, no event.
  - E1: load the pause-swallow counter with 7. The next 7 good bytes are discarded without events, and flags are left untouched.
  - AA, FA, EE, FE, FC with no prefix pending: dropped as device responses.
  - Any other byte: EVENT_VALID = 1 for exactly one cycle, with EVENT_CODE = byte, EVENT_EXTENDED = ext, EVENT_PRESSED = !brk. Then clear ext and brk.
- Output timing:
  - Latency: EVENT_VALID and FRAME_ERROR (parity/stop) assert exactly 1 cycle after the STOP-bit FE cycle.
  - EVENT_CODE, EVENT_EXTENDED and EVENT_PRESSED hold their values until the next event.
- EVENT_VALID and FRAME_ERROR are never high in the same cycle.
- There is no backpressure. Frames arrive at least ~60 us apart, so events cannot collide.

Test Plan:
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 12.5 kHz PS/2 clock -> one EVENT_VALID with CODE=1C, EXT=0, PRESSED=1, 1 cycle after the stop FE; FRAME_ERROR stays 0.
- Bytes F0,1C -> a single event with CODE=1C, PRESSED=0, EXT=0. Bytes E0,F0,75 -> a single event with CODE=75, EXT=1, PRESSED=0; flags are clear afterwards.
- Frame 0x1C with parity bit 1 -> FRAME_ERROR pulse, no event. A following good 0x29 -> event CODE=29.
- Send E0, then a frame truncated after 5 data bits and held idle -> FRAME_ERROR exactly TIMEOUT_CYCLES after the last FE, FSM in IDLE. A following 0x1C -> event with EXT=0 (prefix cleared).
- A 5-cycle low glitch on PS2_CLK in IDLE and mid-frame -> no FE; the frame still decodes correctly.
- Sequence E1,14,77,E1,F0,14,F0,77 -> no events. A following 0x1C -> event. Assert RESET mid-frame -> outputs 0 immediately; the next full frame decodes.
